// File: rtl/apb_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_regs
// Brief    : APB register slave: read-only ID at register 0, RW registers above.
//            `APB_SLV_WAIT_STATES_EN enables the WAIT_CYCLES access wait counter.
// Revision : 1.0 - initial release
// ============================================================================
module apb_slave_regs #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 8,
    parameter int                    WAIT_CYCLES = 2,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic                  i_clk_apb,
    input  logic                  i_rst_apb,
    input  logic                  i_psel,
    input  logic                  i_penable,
    input  logic                  i_pwrite,
    input  logic [ADDR_WIDTH-1:0] i_paddr,
    input  logic [DATA_WIDTH-1:0] i_pwdata,
    output logic [DATA_WIDTH-1:0] o_prdata,
    output logic                  o_pready,
    output logic                  o_pslverr
);

    localparam int c_idx_w = $clog2(NUM_REGS);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("apb_slave_regs: WAIT_CYCLES must be in 0..15");
    end
    if (NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_num_regs
        $error("apb_slave_regs: NUM_REGS must be a power of 2, at least 2");
    end

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];

    logic                    w_setup;
    logic                    w_cnt_zero;
    logic                    w_complete;
    logic [c_idx_w-1:0]      w_idx;
    logic [ADDR_WIDTH-1:0]   w_upper;
    logic                    w_legal;
    logic                    w_err;
    logic [DATA_WIDTH-1:0]   w_rd_val;

    assign w_setup = i_psel & ~i_penable;

`ifdef APB_SLV_WAIT_STATES_EN
    logic [3:0] r_wait_cnt;

    always_ff @(posedge i_clk_apb) begin
        if (i_rst_apb) begin
            r_wait_cnt <= 4'd0;
        end else if (r_state == S_IDLE && w_setup) begin
            r_wait_cnt <= 4'(WAIT_CYCLES);
        end else if (r_state == S_ACCESS && r_wait_cnt != 4'd0) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
        end
    end

    assign w_cnt_zero = (r_wait_cnt == 4'd0);
`else
    assign w_cnt_zero = 1'b1;
`endif

    assign w_complete = (r_state == S_ACCESS) & w_cnt_zero & i_psel & i_penable;

    // Decode works on the address captured at setup, not the live bus.
    assign w_idx    = r_addr[2 +: c_idx_w];
    assign w_upper  = r_addr >> (c_idx_w + 2);
    assign w_legal  = (r_addr[1:0] == 2'b00) && (w_upper == '0);
    assign w_err    = ~w_legal | (r_write & (w_idx == '0));
    assign w_rd_val = (w_idx == '0) ? ID_VALUE : r_regs[w_idx];

    assign o_pready  = w_complete;
    assign o_pslverr = w_complete & w_err;
    assign o_prdata  = (w_complete & ~r_write & ~w_err) ? w_rd_val : '0;

    always_ff @(posedge i_clk_apb) begin
        if (i_rst_apb) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_setup) begin
                    w_state_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!i_psel || w_complete) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_apb) begin
        if (i_rst_apb) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
        end else if (r_state == S_IDLE && w_setup) begin
            r_addr  <= i_paddr;
            r_write <= i_pwrite;
            r_wdata <= i_pwdata;
        end
    end

    // Register 0 is never written: any write to it is flagged as an error.
    always_ff @(posedge i_clk_apb) begin
        if (i_rst_apb) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_complete && r_write && !w_err) begin
            r_regs[w_idx] <= r_wdata;
        end
    end

endmodule
`default_nettype wire

// File: doc/apb_slave_regs.md
APB_SLAVE_REGS -- requirements
Module: apb_slave_regs

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, register/data width.
- NUM_REGS, 8, register count (power of 2, at least 2).
- WAIT_CYCLES, 2, access-phase wait states (0..15).
- ID_VALUE, 32'hA5B0_0001, constant returned by register 0.

REQ-002 The block SHALL have these ports (clock and reset first):
- i_clk_apb, input, 1, sole clock; all state updates on rising edge.
- i_rst_apb, input, 1, synchronous active-high reset.
- i_psel, input, 1, slave select.
- i_penable, input, 1, access phase.
- i_pwrite, input, 1, 1=write, 0=read.
- i_paddr, input, ADDR_WIDTH, byte address.
- i_pwdata, input, DATA_WIDTH, write data.
- o_prdata, output, DATA_WIDTH, read data.
- o_pready, output, 1, transfer complete.
- o_pslverr, output, 1, transfer error.

REQ-003 The block SHALL sit downstream of apb_master and SHALL present a single-clock, synchronous, active-high reset on i_clk_apb/i_rst_apb.

Function
REQ-004 The FSM SHALL have two states, IDLE and ACCESS, with a 4-bit wait counter.

REQ-005 IDLE transitions:
- i_psel=1 and i_penable=0 (setup) SHALL move to ACCESS next cycle.
- i_paddr, i_pwrite and i_pwdata SHALL be captured at that edge.
- The counter SHALL be loaded with WAIT_CYCLES at that edge.

REQ-006 In ACCESS, o_pready SHALL be 1 only when the counter is 0.
- The counter SHALL decrement by 1 per cycle while nonzero.

REQ-007 Completion SHALL be the cycle with ACCESS, counter=0, i_psel=1 and i_penable=1.
- The next state SHALL be IDLE.
- Back-to-back transfers SHALL therefore need a new setup cycle.

REQ-008 If i_psel=0 in ACCESS, the transfer SHALL be aborted:
- next state IDLE;
- no register update;
- o_pready stays 0.

REQ-009 Address decoding:
- index = captured address bits [2 +: log2(NUM_REGS)].
- The address is legal only if bits [1:0]=0 and all bits above the index field are 0.

REQ-010 Register 0 SHALL be read-only and return ID_VALUE.
- Registers 1..NUM_REGS-1 SHALL be read/write with reset value 0.

REQ-011 A legal write SHALL update the register at the completion edge.
- The new value SHALL be visible to a read that starts in the next setup cycle.

REQ-012 o_pslverr SHALL be 1 in the completion cycle for:
- an illegal address;
- a write to register 0.
No register SHALL change on an erroring transfer.

REQ-013 o_prdata SHALL carry the addressed register during a read completion cycle.
- It SHALL be 0 on an error and in all other cycles.
- o_pslverr SHALL be 0 outside completion cycles.

REQ-014 i_psel=1 with i_penable=1 while in IDLE (protocol violation) SHALL be ignored; the FSM stays in IDLE.

Reset
REQ-015 i_rst_apb=1 at a rising edge SHALL force:
- state IDLE and counter 0;
- all RW registers to 0;
- o_pready=0, o_pslverr=0, o_prdata=0, from the following cycle.

REQ-016 Reset asserted during ACCESS SHALL abort the transfer with no register update, and SHALL override a same-cycle completion.

Configuration
REQ-017 The macro APB_SLV_WAIT_STATES_EN SHALL select the wait-state behaviour.
- Defined: the wait counter is implemented and WAIT_CYCLES applies as in REQ-005/REQ-006.
- Undefined: the counter is not implemented, and every transfer completes in its first access cycle (o_pready=1 whenever ACCESS, i_psel=1 and i_penable=1), regardless of WAIT_CYCLES.

Verification
REQ-018 Read ID: setup then access at 0x00 -> o_pready=1 after 2 wait cycles (macro defined), o_prdata=32'hA5B0_0001, o_pslverr=0.

REQ-019 Write then read: write 0xDEADBEEF to 0x08, then read 0x08 -> o_prdata=0xDEADBEEF, o_pslverr=0 on both transfers.

REQ-020 Errors, each giving o_pslverr=1 and unchanged register state:
- write 0x1234 to 0x00;
- read 0x02 (misaligned) -> o_prdata=0;
- read 0x20 (out of range for NUM_REGS=8) -> o_prdata=0.

REQ-021 Abort: drop i_psel in the first wait cycle of a write to 0x04 -> read 0x04 returns 0.

REQ-022 Reset mid-transfer: write 0x55 to 0x0C, then assert i_rst_apb on the completion cycle -> o_pready=0 next cycle, and a read of 0x0C returns 0.

REQ-023 Macro undefined: read 0x00 -> o_pready=1 in the first access cycle, o_prdata=32'hA5B0_0001.
